// File: rtl/fifo_rd_streamer_pkg.sv
// ============================================================================
//  Module      : Shared_Pkg
//  Description : Constants and types shared by the FIFO and its read-side
//                streamer. FIFO_WIDTH is the FIFO word width; the streamer
//                defaults (output buffer depth, transfer counter width) live
//                here so that integrators can tune them in one place.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package Shared_Pkg;

    localparam int FIFO_WIDTH       = 16;
    localparam int STREAM_BUF_DEPTH = 3;
    localparam int XFER_CNT_WIDTH   = 16;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage : Shared_Pkg

`default_nettype wire

// File: rtl/fifo_rd_streamer_skid_buf.sv
// ============================================================================
//  Module      : stream_skid_buf
//  Description : Small circular output buffer for the FIFO read streamer.
//                Words are pushed at the write pointer and presented at the
//                read pointer; both pointers wrap at DEPTH. The head word and
//                the valid flag come straight from registers.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                i_push/i_push_data - write one word
//                i_pop             - consume the head word (ignored if empty)
//                o_data/o_valid    - head word and "buffer not empty"
//                o_occ             - number of buffered words (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [OCC_W-1:0] o_occ
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop on an empty buffer is meaningless; drop it rather than corrupt occ.
    assign w_pop = i_pop & (r_occ != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Storage is cleared too so the head word reads 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            if (i_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (!i_push && w_pop) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    // The upstream credit rule must never let a push land on a full buffer.
    always_ff @(posedge clk) begin : p_overflow_chk
        if (rst_n && i_push && !w_pop) begin
            assert (r_occ != OCC_W'(DEPTH));
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_occ != '0);
    assign o_occ   = r_occ;

endmodule : stream_skid_buf

`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
// ============================================================================
//  Module      : fifo_rd_streamer
//  Description : Read-side consumer of the synchronous FIFO. Issues FIFO
//                reads against a credit budget (buffered + in-flight words
//                must stay below BUF_DEPTH), captures the data one cycle
//                later into a small output buffer and presents it as a
//                valid/ready stream. fifo_rd_en never depends on m_ready.
//                Counts accepted words and flags FIFO underflow (sticky).
//  Ports       : clk, rst_n                    - clock, sync active-low reset
//                enable                        - permit new FIFO reads
//                fifo_data_out/empty/underflow - FIFO read-side status/data
//                fifo_rd_en                    - FIFO read request
//                m_data/m_valid/m_ready        - output stream
//                xfer_count                    - accepted-word counter (wraps)
//                err_underflow                 - sticky underflow error
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_streamer
    import Shared_Pkg::*;
#(
    parameter int FIFO_WIDTH = Shared_Pkg::FIFO_WIDTH,
    parameter int BUF_DEPTH  = STREAM_BUF_DEPTH,
    parameter int CNT_WIDTH  = XFER_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic                  err_underflow
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_xfer_count;
    logic                 r_err_underflow;

    logic [OCC_W-1:0]     w_occ;
    logic [OCC_W:0]       w_credit_used;
    logic                 w_push;
    logic                 w_pop;

    // Credit check uses only registered state, so m_ready has no path here.
    assign w_credit_used = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight};
    assign fifo_rd_en    = rst_n & enable & ~fifo_empty
                         & (w_credit_used < (OCC_W + 1)'(BUF_DEPTH));

    // A word returned with the underflow flag is garbage and is dropped.
    assign w_push = r_inflight & ~fifo_underflow;
    assign w_pop  = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_xfer_count    <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_pop) begin
                r_xfer_count <= r_xfer_count + 1'b1;
            end
            if (r_inflight && fifo_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    stream_skid_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_skid_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (fifo_data_out),
        .i_pop       (w_pop),
        .o_data      (m_data),
        .o_valid     (m_valid),
        .o_occ       (w_occ)
    );

    assign xfer_count    = r_xfer_count;
    assign err_underflow = r_err_underflow;

endmodule : fifo_rd_streamer

`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
// ============================================================================
//  Module      : tb_fifo_rd_streamer
//  Description : Self-checking bench for fifo_rd_streamer. A queue stands in
//                for the FIFO; a reference model (queue of buffered words,
//                pending-read bit, counter, sticky error) predicts every
//                output each cycle. Directed phases follow the test plan,
//                then a randomized phase with resets and underflow hits.
//                The counter is instantiated 8 bits wide so wrap is reached.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_streamer;

    localparam int W  = 16;
    localparam int D  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic          fifo_rd_en;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] xfer_count;
    logic          err_underflow;

    always #5 clk = ~clk;

    fifo_rd_streamer #(
        .FIFO_WIDTH (W),
        .BUF_DEPTH  (D),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .xfer_count     (xfer_count),
        .err_underflow  (err_underflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] src[$];   // FIFO contents
    logic [W-1:0] mq[$];    // model: words held in the output buffer
    bit  pend;              // model: read issued last cycle
    int  cnt;               // model: words accepted since reset
    bit  err_m;             // model: sticky underflow
    int  rd_pulses;
    int  reads_in_phase;
    int  inj_read;
    bit  rand_inj;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check, advance model at posedge.
    task automatic cycle(input bit en, input bit rdy, input bit rn);
        bit exp_rd, exp_v, did_rd, popm;
        rst_n      = rn;
        enable     = en;
        m_ready    = rdy;
        fifo_empty = (src.size() == 0);
        #1;
        exp_rd = rn && en && (src.size() != 0) && ((mq.size() + int'(pend)) < D);
        exp_v  = (mq.size() != 0);
        chk("rd_en", fifo_rd_en, exp_rd);
        chk("m_valid", m_valid, exp_v);
        if (exp_v) chk("m_data", m_data, mq[0]);
        chk("xfer_count", xfer_count, cnt % (1 << CW));
        chk("err_underflow", err_underflow, err_m);
        did_rd = fifo_rd_en;
        if (did_rd) rd_pulses++;
        popm = exp_v && rdy;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            pend  = 0;
            cnt   = 0;
            err_m = 0;
        end else begin
            if (popm) begin
                void'(mq.pop_front());
                cnt++;
            end
            if (pend) begin
                if (fifo_underflow) err_m = 1;
                else                mq.push_back(fifo_data_out);
            end
            pend = exp_rd;
        end
        #1;
        // FIFO answers a read with data (and flags) during the next cycle.
        if (did_rd && src.size() != 0) begin
            reads_in_phase++;
            fifo_data_out  = src.pop_front();
            fifo_underflow = (reads_in_phase == inj_read) ||
                             (rand_inj && $urandom_range(0, 63) == 0);
        end else begin
            fifo_data_out  = W'($urandom);
            fifo_underflow = did_rd;   // a read of an empty FIFO underflows
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; enable = 1; m_ready = 1; fifo_empty = 0;
        fifo_data_out = '0; fifo_underflow = 0;
        pend = 0; cnt = 0; err_m = 0; rd_pulses = 0;
        reads_in_phase = 0; inj_read = 0; rand_inj = 0;
        @(posedge clk);
        @(negedge clk);

        // 1. Reset hold with a non-empty FIFO
        for (int i = 0; i < 3; i++) src.push_back(W'(16'h1111 * (i + 1)));
        for (int i = 0; i < 3; i++) cycle(1, 1, 0);
        chk("reset_m_data", m_data, 0);
        src.delete();

        // 2. Single word
        src.push_back(16'hA5A5);
        for (int i = 0; i < 5; i++) cycle(1, 1, 1);
        chk("single_count", xfer_count, 1);

        // 3. Streaming eight words
        for (int i = 1; i <= 8; i++) src.push_back(W'(i));
        for (int i = 0; i < 12; i++) cycle(1, 1, 1);
        chk("stream_count", xfer_count, 9);
        chk("stream_idle", m_valid, 0);

        // 4. Backpressure
        for (int i = 1; i <= 8; i++) src.push_back(W'(i));
        rd_pulses = 0;
        for (int i = 0; i < 10; i++) cycle(1, 0, 1);
        chk("bp_reads", rd_pulses, 3);
        chk("bp_head", m_data, 16'h0001);
        for (int i = 0; i < 15; i++) cycle(1, 1, 1);
        chk("bp_count", xfer_count, 17);

        // 5. Underflow on read #2 of 3
        src.push_back(16'h00B1); src.push_back(16'h00B2); src.push_back(16'h00B3);
        reads_in_phase = 0; inj_read = 2;
        for (int i = 0; i < 8; i++) cycle(1, 1, 1);
        chk("uf_count", xfer_count, 19);
        chk("uf_flag", err_underflow, 1);
        inj_read = 0;
        for (int i = 0; i < 3; i++) cycle(1, 1, 1);
        chk("uf_sticky", err_underflow, 1);
        cycle(1, 1, 0);
        cycle(1, 1, 1);

        // 6a. Mid-stream reset with two buffered words
        for (int i = 1; i <= 6; i++) src.push_back(W'(16'h0C00 + i));
        cycle(1, 0, 1); cycle(1, 0, 1); cycle(0, 0, 1); cycle(0, 0, 1);
        chk("pre_reset_valid", m_valid, 1);
        cycle(1, 0, 0);
        chk("post_reset_valid", m_valid, 0);
        src.delete();
        for (int i = 0; i < 4; i++) cycle(1, 1, 1);

        // 6b. Counter wrap: 257 words through an 8-bit counter
        for (int i = 0; i < 257; i++) src.push_back(W'($urandom));
        for (int i = 0; i < 265; i++) cycle(1, 1, 1);
        chk("wrap_count", xfer_count, 1);

        // Random phase
        rand_inj = 1;
        for (int i = 0; i < 3000; i++) begin
            if (src.size() < 4 && $urandom_range(0, 3) == 0)
                for (int k = 0; k < int'($urandom_range(1, 6)); k++) src.push_back(W'($urandom));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 299) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_rd_streamer

`default_nettype wire

// File: doc/fifo_rd_streamer.md
Name: fifo_rd_streamer

Overview:
- Downstream consumer of the synchronous FIFO.
- Pulls words out of the FIFO read port and presents them as a valid/ready stream (m_valid/m_ready).
- Hides the FIFO's one-cycle read latency with a small output buffer, so throughput is one word per cycle without a combinational path from m_ready to the FIFO's rd_en.
- Counts delivered words and flags FIFO underflow on any read it issued.

Parameters:
- FIFO_WIDTH, default Shared_Pkg::FIFO_WIDTH (16): data word width; must match the FIFO.
- BUF_DEPTH, default 3: output buffer entries; legal range 3..8.
- CNT_WIDTH, default 16: width of xfer_count.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  synchronous active-low reset
- enable  in  1  when 1, the block may issue FIFO reads
- fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_underflow  in  1  FIFO underflow flag, coincident with read data
- fifo_rd_en  out  1  read request to the FIFO
- m_data  out  FIFO_WIDTH  stream data (buffer head)
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- xfer_count  out  CNT_WIDTH  number of words accepted downstream
- err_underflow  out  1  sticky underflow error

Behaviour:
- Reset (rst_n low at posedge):
  - Buffer cleared (occ=0), inflight=0, xfer_count=0, err_underflow=0.
  - m_valid=0, m_data=0.
  - fifo_rd_en is forced 0 combinationally while rst_n is low.
  - Reset mid-operation discards buffered and in-flight words; no partial state survives.
- State:
  - occ (0..BUF_DEPTH): buffered word count.
  - inflight (1 bit): a read was issued last cycle.
  - Circular buffer with rd/wr pointers that wrap at BUF_DEPTH.
- Read issue (combinational): fifo_rd_en = rst_n & enable & !fifo_empty & (occ + inflight < BUF_DEPTH).
  - Depends on registered state, enable and fifo_empty only; never on m_ready.
- inflight_next = fifo_rd_en.
- Capture: in a cycle with inflight=1:
  - If fifo_underflow=0, push fifo_data_out at wr_ptr.
  - If fifo_underflow=1, discard the word (no push) and set err_underflow=1 until reset.
- Pop: in a cycle with m_valid=1 and m_ready=1, advance rd_ptr and increment xfer_count.
  - xfer_count wraps from 2^CNT_WIDTH-1 to 0.
- Push and pop in the same cycle: occ unchanged, both pointers advance.
- The credit rule guarantees no push when occ=BUF_DEPTH. Overflow of the buffer is a design error; assert it in simulation.
- Output: m_valid = (occ != 0) and m_data = buffer[rd_ptr], both driven from registers.
  - While m_valid=1 and m_ready=0, m_data and m_valid hold stable.
  - Output order equals FIFO read order.
- Latency: with an empty buffer, fifo_rd_en in cycle N puts the word on m_data with m_valid=1 in cycle N+2 (captured at the end of N+1).
- Throughput: with m_ready held 1 and the FIFO non-empty, one word per cycle in steady state.
- enable deassert: no new reads are issued. A read already in flight is still captured, and buffered words still drain. Re-assert resumes with no loss.
- FIFO empty: no read is issued. The buffer keeps draining, and m_valid falls when occ reaches 0.
- Downstream stall (m_ready=0): reads stop once occ+inflight reaches BUF_DEPTH.

Decomposition:
- Shared_Pkg: FIFO_WIDTH (existing), STREAM_BUF_DEPTH=3 and XFER_CNT_WIDTH=16 constants, and typedef fifo_word_t = logic [FIFO_WIDTH-1:0].
- Sub-module stream_skid_buf holds the circular buffer, pointers and occ (push/pop/data/occ interface).
- The top level holds the credit logic, inflight, counter and error flag.
- The interface gains a STREAMER modport: inputs data_out, empty, underflow; output rd_en.

Test Plan:
1. Reset hold: rst_n=0 for 3 cycles with fifo_empty=0 and enable=1 -> fifo_rd_en=0, m_valid=0, xfer_count=0, err_underflow=0 throughout.
2. Single word: FIFO holds 0xA5A5, m_ready=1, enable=1 -> fifo_rd_en high in cycle N; m_valid=1 with m_data=0xA5A5 in N+2; xfer_count=1.
3. Streaming: FIFO holds 0x0001..0x0008, m_ready=1 -> eight consecutive m_valid cycles in ascending order; xfer_count=8; then m_valid=0.
4. Backpressure: m_ready=0 with 8 words queued -> exactly 3 fifo_rd_en pulses and m_data held at 0x0001. Release m_ready -> all 8 words arrive in order with no duplicates.
5. Underflow injection: force fifo_underflow=1 on the data cycle of read #2 of 3 -> only 2 words are delivered, err_underflow=1 and stays 1 until rst_n=0.
6. Mid-stream reset and wrap: reset with occ=2 -> m_valid=0 on the next cycle and no stale data later. Preload xfer_count near 0xFFFF and transfer 2 words -> count wraps 0xFFFF to 0x0000.
